// File: rtl/maverickone_instr_launcher.sv
// Decoded-instruction launcher: one-entry holding stage that issues to execute once
// register locks, the outstanding limit and blocking-instruction drains allow.
package maverickone_pkg;
  localparam int NUM_REGS        = 64;
  localparam int NUM_OUTSTANDING = 7;

  // reg_req marks every register the instruction reads or writes (GPR 0-31, FPR 32-63).
  typedef struct packed {
    logic [7:0]          op;
    logic [5:0]          rd;
    logic [5:0]          rs1;
    logic [5:0]          rs2;
    logic [NUM_REGS-1:0] reg_req;
    logic                blocking;
  } decoded_instr_t;
endpackage

module maverickone_instr_launcher
  import maverickone_pkg::*;
#(
  parameter int NUM_OUTSTANDING = maverickone_pkg::NUM_OUTSTANDING,
  parameter int NUM_REGS        = maverickone_pkg::NUM_REGS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  decoded_instr_t      in_instr_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output decoded_instr_t      out_instr_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  input  logic                wb_valid_i,
  input  logic [5:0]          wb_rd_i,
  output logic [NUM_REGS-1:0] locks_o,
  output logic [2:0]          outstanding_o,
  output logic [1:0]          state_o
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid never depends on ready, and a raised valid holds its payload until the transfer.

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_HELD    = 2'd1,
    S_BLOCKED = 2'd2
  } state_t;

  localparam logic [2:0] MAX_OUT = 3'(NUM_OUTSTANDING);

  state_t              state_q, state_d;
  decoded_instr_t      held_q, held_d;
  logic                held_valid_q, held_valid_d;
  logic [NUM_REGS-1:0] locks_q, locks_d;
  logic [2:0]          outstanding_q, outstanding_d;
  logic                blk_pend_q, blk_pend_d;
  logic                haz, out_fire, in_fire;

  always_comb begin
    haz = (|(held_q.reg_req & locks_q))
        | (outstanding_q == MAX_OUT)
        | blk_pend_q
        | (held_q.blocking & (outstanding_q != 3'd0));
    out_valid_o = held_valid_q & ~haz;
    out_fire    = out_valid_o & out_ready_i;
    in_ready_o  = ~held_valid_q | out_fire;
    in_fire     = in_valid_i & in_ready_o;
  end

  // Issue and completion in the same cycle cancel; a stray completion at zero is ignored.
  always_comb begin
    outstanding_d = outstanding_q;
    if (out_fire && !wb_valid_i)
      outstanding_d = outstanding_q + 3'd1;
    else if (!out_fire && wb_valid_i && outstanding_q != 3'd0)
      outstanding_d = outstanding_q - 3'd1;
  end

  // Clear before set so a same-index issue keeps its new lock.
  always_comb begin
    locks_d = locks_q;
    if (wb_valid_i)
      locks_d[wb_rd_i] = 1'b0;
    if (out_fire && held_q.rd != 6'd0 && held_q.reg_req[held_q.rd])
      locks_d[held_q.rd] = 1'b1;
    locks_d[0] = 1'b0;
  end

  always_comb begin
    blk_pend_d = (blk_pend_q | (out_fire & held_q.blocking)) & (outstanding_d != 3'd0);
    held_d     = held_q;
    if (in_fire && !flush_i)
      held_d = in_instr_i;
    if (flush_i)
      held_valid_d = 1'b0;
    else if (in_fire)
      held_valid_d = 1'b1;
    else if (out_fire)
      held_valid_d = 1'b0;
    else
      held_valid_d = held_valid_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: begin
        if (in_fire && !flush_i) state_d = S_HELD;
      end
      S_HELD: begin
        if (out_fire) begin
          if (in_fire && !flush_i)  state_d = S_HELD;
          else if (held_q.blocking) state_d = S_BLOCKED;
          else                      state_d = S_EMPTY;
        end else if (flush_i) begin
          state_d = S_EMPTY;
        end
      end
      S_BLOCKED: begin
        if (outstanding_d == 3'd0) state_d = held_valid_d ? S_HELD : S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_EMPTY;
      held_q        <= '0;
      held_valid_q  <= 1'b0;
      locks_q       <= '0;
      outstanding_q <= 3'd0;
      blk_pend_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      held_q        <= held_d;
      held_valid_q  <= held_valid_d;
      locks_q       <= locks_d;
      outstanding_q <= outstanding_d;
      blk_pend_q    <= blk_pend_d;
    end
  end

  assign out_instr_o   = held_q;
  assign locks_o       = locks_q;
  assign outstanding_o = outstanding_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_maverickone_instr_launcher.sv
// Bench for maverickone_instr_launcher: directed scenarios plus random traffic, all
// compared every cycle against a cycle-level behavioural model of the issue rules.
module tb_maverickone_instr_launcher;
  import maverickone_pkg::*;

  logic           clk = 1'b0;
  logic           rst, flush, in_valid, out_ready, wb_valid;
  decoded_instr_t in_instr;
  logic [5:0]     wb_rd;
  logic           in_ready, out_valid;
  decoded_instr_t out_instr;
  logic [63:0]    locks;
  logic [2:0]     outstanding;
  logic [1:0]     state;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit             m_held;
  decoded_instr_t m_instr;
  bit             m_lock [64];
  int             m_cnt;
  bit             m_drain;
  bit             m_valid, m_fire, m_rdy, m_acc;

  always #5 clk = ~clk;

  maverickone_instr_launcher dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_instr_i(in_instr), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_instr_o(out_instr), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
    .locks_o(locks), .outstanding_o(outstanding), .state_o(state)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic decoded_instr_t mk(input int rd, input int rs1, input int rs2, input bit blk);
    decoded_instr_t d;
    d = '0;
    d.op = 8'($urandom_range(1, 255));
    d.rd = 6'(rd);
    d.rs1 = 6'(rs1);
    d.rs2 = 6'(rs2);
    d.reg_req[rd] = 1'b1;
    d.reg_req[rs1] = 1'b1;
    d.reg_req[rs2] = 1'b1;
    d.blocking = blk;
    return d;
  endfunction

  task automatic model_reset();
    m_held = 0; m_instr = '0; m_cnt = 0; m_drain = 0;
    for (int i = 0; i < 64; i++) m_lock[i] = 0;
  endtask

  // What the launcher should present this cycle, given model state and current inputs.
  task automatic model_comb();
    bit stall;
    stall = (m_cnt == 7) || m_drain || (m_instr.blocking && m_cnt > 0);
    for (int i = 0; i < 64; i++)
      if (m_instr.reg_req[i] && m_lock[i]) stall = 1;
    m_valid = m_held && !stall;
    m_fire  = m_valid && out_ready;
    m_rdy   = !m_held || m_fire;
    m_acc   = in_valid && m_rdy;
  endtask

  task automatic model_seq();
    int delta;
    if (rst) begin
      model_reset();
      return;
    end
    delta = (m_fire ? 1 : 0) - (wb_valid ? 1 : 0);
    if (m_cnt + delta < 0) delta = 0;
    m_cnt += delta;
    if (wb_valid) m_lock[wb_rd] = 0;
    if (m_fire && m_instr.rd != 0 && m_instr.reg_req[m_instr.rd]) m_lock[m_instr.rd] = 1;
    if (m_fire && m_instr.blocking) m_drain = 1;
    if (m_cnt == 0) m_drain = 0;
    if (flush) m_held = 0;
    else if (m_acc) begin m_held = 1; m_instr = in_instr; end
    else if (m_fire) m_held = 0;
  endtask

  // One clock: compare every output against the model, then advance both.
  task automatic cyc();
    logic [63:0] exp_locks;
    #1;
    model_comb();
    for (int i = 0; i < 64; i++) exp_locks[i] = m_lock[i];
    chk("out_valid", 128'(out_valid), 128'(m_valid));
    chk("in_ready", 128'(in_ready), 128'(m_rdy));
    chk("out_instr", 128'(out_instr), 128'(m_instr));
    chk("locks", 128'(locks), 128'(exp_locks));
    chk("outstanding", 128'(outstanding), 128'(m_cnt));
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic send(input decoded_instr_t d);
    bit done = 0;
    in_valid = 1; in_instr = d;
    for (int k = 0; k < 40 && !done; k++) begin
      #1;
      model_comb();
      done = m_acc;
      cyc();
    end
    in_valid = 0;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout observed=not_accepted expected=accepted");
    end
  endtask

  task automatic wb(input int rd);
    wb_valid = 1; wb_rd = 6'(rd);
    cyc();
    wb_valid = 0;
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 1; wb_valid = 0; wb_rd = '0; in_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();

    // Reset state
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_out_instr", 128'(out_instr), 128'(0));
    chk("reset_locks", 128'(locks), 128'(0));
    chk("reset_outstanding", 128'(outstanding), 128'(0));
    chk("reset_state", 128'(state), 128'(0));

    // ADD rd=5: visible one cycle after accept, then locks rd
    send(mk(5, 1, 2, 0));
    chk("add_valid_c2", 128'(out_valid), 128'(1));
    cyc();
    chk("add_lock5", 128'(locks[5]), 128'(1));
    chk("add_outstanding", 128'(outstanding), 128'(1));
    wb(5);

    // RAW: SUB reading x5 waits for its writeback
    send(mk(5, 1, 2, 0));
    send(mk(6, 5, 3, 0));
    for (int k = 0; k < 3; k++) begin
      chk("sub_stall", 128'(out_valid), 128'(0));
      cyc();
    end
    wb(5);
    chk("sub_after_wb", 128'(out_valid), 128'(1));
    cyc();
    wb(6);

    // Outstanding limit
    for (int r = 1; r <= 8; r++) send(mk(r, 0, 0, 0));
    cyc();
    chk("limit_count", 128'(outstanding), 128'(7));
    chk("limit_stall", 128'(out_valid), 128'(0));
    wb(1);
    chk("limit_release", 128'(out_valid), 128'(1));
    cyc();
    chk("limit_refill", 128'(outstanding), 128'(7));
    for (int r = 2; r <= 8; r++) wb(r);
    chk("limit_drained", 128'(outstanding), 128'(0));

    // Blocking FENCE drains, then holds back the next instruction until its own wb
    for (int r = 10; r <= 12; r++) send(mk(r, 0, 0, 0));
    send(mk(0, 0, 0, 1));
    chk("fence_wait", 128'(out_valid), 128'(0));
    for (int r = 10; r <= 12; r++) wb(r);
    chk("fence_issue", 128'(out_valid), 128'(1));
    send(mk(13, 1, 0, 0));
    for (int k = 0; k < 3; k++) begin
      chk("post_fence_stall", 128'(out_valid), 128'(0));
      cyc();
    end
    wb(0);
    chk("post_fence_go", 128'(out_valid), 128'(1));
    cyc();
    wb(13);

    // Same-cycle issue and writeback
    send(mk(3, 0, 0, 0));
    send(mk(9, 0, 0, 0));
    chk("same_pre_count", 128'(outstanding), 128'(1));
    wb(3);
    chk("same_count", 128'(outstanding), 128'(1));
    chk("same_lock9", 128'(locks[9]), 128'(1));
    chk("same_lock3", 128'(locks[3]), 128'(0));
    wb(9);

    // Flush of a stalled instruction
    send(mk(20, 0, 0, 0));
    send(mk(21, 20, 0, 0));
    flush = 1; cyc(); flush = 0;
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_count", 128'(outstanding), 128'(1));
    chk("flush_lock20", 128'(locks[20]), 128'(1));
    wb(20);
    chk("flush_gone", 128'(out_valid), 128'(0));

    // Reset mid-flight, then a late writeback
    for (int r = 24; r <= 27; r++) send(mk(r, 0, 0, 0));
    cyc();
    chk("pre_rst_count", 128'(outstanding), 128'(4));
    rst = 1; cyc(); rst = 0;
    chk("rst_count", 128'(outstanding), 128'(0));
    chk("rst_locks", 128'(locks), 128'(0));
    wb(24);
    chk("late_wb_count", 128'(outstanding), 128'(0));

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_instr  = mk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      wb_valid  = ($urandom_range(0, 9) < 4);
      wb_rd     = 6'($urandom_range(0, 15));
      flush     = ($urandom_range(0, 29) == 0);
      cyc();
    end
    in_valid = 0; wb_valid = 0; flush = 0; out_ready = 1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
